// File: rtl/main_memory_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter and its beat sequencer.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

    localparam int LINE_WORDS_DEFAULT = 4;
    localparam int MEM_LAT_DEFAULT    = 2;
    localparam int LINE_OFFSET_BITS   = 4;

    // Line base: the byte offset within a 16-byte line is forced to zero.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/main_memory_arbiter_if.sv
// Single-ported main-memory bus; the arbiter is the only master.
interface main_memory_arbiter_if;
    logic        mem_en;
    logic        mem_rd_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport master (
        output mem_en, mem_rd_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid
    );

    modport slave (
        input  mem_en, mem_rd_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_valid
    );
endinterface

// File: rtl/main_memory_arbiter_beat_counter.sv
// Beat index and per-word latency counter; sample fires when the word's data is taken.
module mem_beat_counter
    import mem_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter int MEM_LAT    = MEM_LAT_DEFAULT,
    parameter int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              active,
    input  logic              stall,
    output logic [BEAT_W-1:0] beat,
    output logic              sample,
    output logic              last_beat
);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              lat_end_s;

    assign lat_end_s = (lat_q == LAT_W'(MEM_LAT - 1));
    assign sample    = active && lat_end_s && !stall;
    assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign beat      = beat_q;

    // Next-state: count latency, advance beat on a non-stalled sample, hold while stalled.
    always_comb begin
        beat_d = beat_q;
        lat_d  = lat_q;
        if (clear) begin
            beat_d = {BEAT_W{1'b0}};
            lat_d  = {LAT_W{1'b0}};
        end else if (!active) begin
            beat_d = beat_q;
            lat_d  = lat_q;
        end else if (!lat_end_s) begin
            lat_d = lat_q + LAT_W'(1);
        end else if (!stall) begin
            lat_d  = {LAT_W{1'b0}};
            beat_d = last_beat ? {BEAT_W{1'b0}} : beat_q + BEAT_W'(1);
        end else begin
            beat_d = beat_q;
            lat_d  = lat_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= {BEAT_W{1'b0}};
            lat_q  <= {LAT_W{1'b0}};
        end else begin
            beat_q <= beat_d;
            lat_q  <= lat_d;
        end
    end

endmodule

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter and line sequencer sharing main memory between icache and dcache fills.
module main_memory_arbiter
    import mem_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter int MEM_LAT    = MEM_LAT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ic_req,
    input  logic [31:0]                ic_addr,
    output logic                       ic_ack,
    output logic [32*LINE_WORDS-1:0]   ic_line,
    input  logic                       dc_req,
    input  logic                       dc_rd_wr,
    input  logic [31:0]                dc_addr,
    input  logic [32*LINE_WORDS-1:0]   dc_wdata,
    output logic                       dc_ack,
    output logic [32*LINE_WORDS-1:0]   dc_line,
    main_memory_arbiter_if.master      mem
);
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    arb_state_e state_q, state_d;
    req_id_e    grant_q, grant_d, last_grant_q, last_grant_d, pick_s;
    logic [31:0] base_q, base_d;
    logic        dir_q, dir_d;
    logic [LINE_WORDS-1:0][31:0] wline_q, wline_d, line_q, line_d;
    logic        mem_en_q, mem_en_d, mem_rd_wr_q, mem_rd_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        ic_ack_q, ic_ack_d, dc_ack_q, dc_ack_d;

    logic [BEAT_W-1:0] beat_s, beat_nx_s;
    logic              sample_s, last_beat_s;

    mem_beat_counter #(
        .LINE_WORDS (LINE_WORDS),
        .MEM_LAT    (MEM_LAT),
        .BEAT_W     (BEAT_W)
    ) u_beat (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == ST_IDLE),
        .active    (state_q == ST_ACCESS),
        .stall     (!mem.mem_valid),
        .beat      (beat_s),
        .sample    (sample_s),
        .last_beat (last_beat_s)
    );

    assign beat_nx_s = beat_s + BEAT_W'(1);

    // On a tie the requester not served last wins; a lone requester always wins.
    assign pick_s = (ic_req && dc_req) ? ((last_grant_q == REQ_DC) ? REQ_IC : REQ_DC)
                                       : (ic_req ? REQ_IC : REQ_DC);

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        base_d       = base_q;
        dir_d        = dir_q;
        wline_d      = wline_q;
        line_d       = line_q;
        mem_en_d     = mem_en_q;
        mem_rd_wr_d  = mem_rd_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ic_ack_d     = 1'b0;
        dc_ack_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ic_req || dc_req) begin
                    grant_d     = pick_s;
                    base_d      = line_base((pick_s == REQ_IC) ? ic_addr : dc_addr);
                    dir_d       = (pick_s == REQ_DC) && dc_rd_wr;
                    wline_d     = (pick_s == REQ_DC) ? dc_wdata : {(32*LINE_WORDS){1'b0}};
                    state_d     = ST_ACCESS;
                    mem_en_d    = 1'b1;
                    mem_rd_wr_d = dir_d;
                    mem_addr_d  = base_d;
                    mem_wdata_d = dir_d ? wline_d[0] : 32'h0000_0000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (sample_s) begin
                    if (!dir_q) begin
                        line_d[beat_s] = mem.mem_rdata;
                    end else begin
                        line_d = line_q;
                    end
                    if (last_beat_s) begin
                        state_d     = ST_DONE;
                        mem_en_d    = 1'b0;
                        mem_rd_wr_d = 1'b0;
                        mem_addr_d  = 32'h0000_0000;
                        mem_wdata_d = 32'h0000_0000;
                        ic_ack_d    = (grant_q == REQ_IC);
                        dc_ack_d    = (grant_q == REQ_DC);
                    end else begin
                        // Word address wraps modulo 2^32 with the line.
                        mem_addr_d  = base_q + 32'({beat_nx_s, 2'b00});
                        mem_wdata_d = dir_q ? wline_q[beat_nx_s] : 32'h0000_0000;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_IC;
            last_grant_q <= REQ_DC;
            base_q       <= 32'h0000_0000;
            dir_q        <= 1'b0;
            wline_q      <= {(32*LINE_WORDS){1'b0}};
            line_q       <= {(32*LINE_WORDS){1'b0}};
            mem_en_q     <= 1'b0;
            mem_rd_wr_q  <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            ic_ack_q     <= 1'b0;
            dc_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            base_q       <= base_d;
            dir_q        <= dir_d;
            wline_q      <= wline_d;
            line_q       <= line_d;
            mem_en_q     <= mem_en_d;
            mem_rd_wr_q  <= mem_rd_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ic_ack_q     <= ic_ack_d;
            dc_ack_q     <= dc_ack_d;
        end
    end

    assign ic_ack        = ic_ack_q;
    assign dc_ack        = dc_ack_q;
    assign ic_line       = line_q;
    assign dc_line       = line_q;
    assign mem.mem_en    = mem_en_q;
    assign mem.mem_rd_wr = mem_rd_wr_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Scoreboard bench: stimulus queues expected beats and acks, negedge monitors pop and compare.
module tb_main_memory_arbiter;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, dc_req, dc_rd_wr;
    logic [31:0]  ic_addr, dc_addr;
    logic [127:0] dc_wdata, ic_line, dc_line;
    logic         ic_ack, dc_ack;

    always #5 clk = ~clk;

    main_memory_arbiter_if mif();

    main_memory_arbiter #(.LINE_WORDS(4), .MEM_LAT(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_ack   (ic_ack),
        .ic_line  (ic_line),
        .dc_req   (dc_req),
        .dc_rd_wr (dc_rd_wr),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_ack   (dc_ack),
        .dc_line  (dc_line),
        .mem      (mif)
    );

    typedef struct {
        logic         is_dc;
        logic         chk_line;
        logic [127:0] line;
        int           cyc;
    } ack_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        rd_wr;
        logic [31:0] wdata;
    } beat_exp_t;

    ack_exp_t    ack_q[$];
    beat_exp_t   beat_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] stall_addr = 32'h0;
    int          stall_req = 0;
    int          stall_used = 0;
    logic        prev_en = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and per-word bus monitor.
    always @(negedge clk) begin
        logic      samp;
        beat_exp_t e;
        if (mif.mem_en) begin
            if (!prev_en || mif.mem_addr != prev_addr) hold = 0;
            else hold = hold + 1;
        end else begin
            hold = 0;
        end
        prev_en   = mif.mem_en;
        prev_addr = mif.mem_addr;
        samp = mif.mem_en && (hold >= LAT - 1);
        mif.mem_rdata = mem_arr.exists(mif.mem_addr) ? mem_arr[mif.mem_addr] : 32'h0BAD_0000;
        if (samp && stall_used < stall_req && mif.mem_addr == stall_addr) begin
            mif.mem_valid = 1'b0;
            stall_used++;
        end else begin
            mif.mem_valid = 1'b1;
        end
        if (samp && mif.mem_valid) begin
            if (mif.mem_rd_wr) mem_arr[mif.mem_addr] = mif.mem_wdata;
            n_vec++;
            if (beat_q.size() == 0) begin
                n_miss++;
                $display("FAIL beat_unexpected: got addr %h rd_wr %b at cycle %0d, required no access",
                         mif.mem_addr, mif.mem_rd_wr, cyc);
            end else begin
                e = beat_q.pop_front();
                if (mif.mem_addr != e.addr || mif.mem_rd_wr != e.rd_wr ||
                    (e.rd_wr && mif.mem_wdata != e.wdata)) begin
                    n_miss++;
                    $display("FAIL beat: got addr %h rd_wr %b wdata %h, required addr %h rd_wr %b wdata %h",
                             mif.mem_addr, mif.mem_rd_wr, mif.mem_wdata, e.addr, e.rd_wr, e.wdata);
                end
            end
        end
    end

    // Ack monitor.
    always @(negedge clk) begin
        ack_exp_t a;
        if (ic_ack || dc_ack) begin
            n_vec++;
            if (ack_q.size() == 0) begin
                n_miss++;
                $display("FAIL ack_unexpected: got ic_ack %b dc_ack %b at cycle %0d, required none",
                         ic_ack, dc_ack, cyc);
            end else begin
                a = ack_q.pop_front();
                if (ic_ack != !a.is_dc || dc_ack != a.is_dc || cyc != a.cyc) begin
                    n_miss++;
                    $display("FAIL ack_timing: got ic_ack %b dc_ack %b cycle %0d, required ic_ack %b dc_ack %b cycle %0d",
                             ic_ack, dc_ack, cyc, !a.is_dc, a.is_dc, a.cyc);
                end
                if (a.chk_line) begin
                    n_vec++;
                    if (ic_line != a.line || dc_line != a.line) begin
                        n_miss++;
                        $display("FAIL ack_line: got ic_line %h dc_line %h, required %h",
                                 ic_line, dc_line, a.line);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] w0);
        return {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
    endfunction

    task automatic preload(input logic [31:0] base, input logic [31:0] w0);
        for (int k = 0; k < 4; k++) mem_arr[base + 32'(4 * k)] = w0 + 32'(k);
    endtask

    task automatic push_beats(input logic [31:0] base, input logic wr, input logic [127:0] wl, input int n);
        for (int k = 0; k < n; k++) begin
            beat_exp_t e;
            e.addr  = base + 32'(4 * k);
            e.rd_wr = wr;
            e.wdata = wl[32 * k +: 32];
            beat_q.push_back(e);
        end
    endtask

    task automatic push_ack(input logic is_dc, input logic chk, input logic [127:0] line, input int c);
        ack_exp_t a;
        a.is_dc = is_dc; a.chk_line = chk; a.line = line; a.cyc = c;
        ack_q.push_back(a);
    endtask

    task automatic wait_ack(input logic is_dc, input int budget, input string nm);
        int  n = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            if (is_dc ? dc_ack : ic_ack) seen = 1'b1;
            else begin tick(); n++; end
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no ack within %0d cycles, required an ack", nm, budget);
        end
    endtask

    initial begin
        int t0;
        reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_rd_wr = 1'b0;
        ic_addr = 32'h0; dc_addr = 32'h0; dc_wdata = 128'h0;
        repeat (3) tick();
        n_vec++;
        if (mif.mem_en || mif.mem_rd_wr || mif.mem_addr != 32'h0 || mif.mem_wdata != 32'h0 ||
            ic_ack || dc_ack || ic_line != 128'h0 || dc_line != 128'h0) begin
            n_miss++;
            $display("FAIL reset_outputs: got en %b addr %h ack %b%b line %h, required all zero",
                     mif.mem_en, mif.mem_addr, ic_ack, dc_ack, ic_line);
        end
        reset = 1'b0;
        preload(32'h0000_0100, 32'hA0A0_0000);
        preload(32'h0000_0300, 32'hC0C0_0000);
        preload(32'hFFFF_FFF0, 32'hE0E0_0000);
        tick();

        // Single icache read from a mid-line address.
        t0 = cyc; ic_addr = 32'h0000_0104; ic_req = 1'b1;
        push_beats(32'h0000_0100, 1'b0, 128'h0, 4);
        push_ack(1'b0, 1'b1, mk_line(32'hA0A0_0000), t0 + 9);
        wait_ack(1'b0, 40, "ic_read"); ic_req = 1'b0; tick();

        // dcache line write.
        t0 = cyc; dc_addr = 32'h0000_0200; dc_rd_wr = 1'b1; dc_wdata = mk_line(32'hD0D0_0000); dc_req = 1'b1;
        push_beats(32'h0000_0200, 1'b1, mk_line(32'hD0D0_0000), 4);
        push_ack(1'b1, 1'b0, 128'h0, t0 + 9);
        wait_ack(1'b1, 40, "dc_write"); dc_req = 1'b0; dc_rd_wr = 1'b0; tick();

        // Two ties in a row: icache wins both, dcache follows with one dead cycle.
        for (int r = 0; r < 2; r++) begin
            t0 = cyc;
            ic_addr = (r == 0) ? 32'h0000_0104 : 32'h0000_0300;
            dc_addr = (r == 0) ? 32'h0000_0208 : 32'h0000_010C;
            ic_req = 1'b1; dc_req = 1'b1;
            push_beats((r == 0) ? 32'h0000_0100 : 32'h0000_0300, 1'b0, 128'h0, 4);
            push_beats((r == 0) ? 32'h0000_0200 : 32'h0000_0100, 1'b0, 128'h0, 4);
            push_ack(1'b0, 1'b1, (r == 0) ? mk_line(32'hA0A0_0000) : mk_line(32'hC0C0_0000), t0 + 9);
            push_ack(1'b1, 1'b1, (r == 0) ? mk_line(32'hD0D0_0000) : mk_line(32'hA0A0_0000), t0 + 19);
            wait_ack(1'b0, 40, "tie_ic"); ic_req = 1'b0;
            wait_ack(1'b1, 40, "tie_dc"); dc_req = 1'b0; tick();
        end

        // Three stall cycles at beat 2's sample point.
        stall_addr = 32'h0000_0308; stall_req = stall_req + 3;
        t0 = cyc; ic_addr = 32'h0000_030C; ic_req = 1'b1;
        push_beats(32'h0000_0300, 1'b0, 128'h0, 4);
        push_ack(1'b0, 1'b1, mk_line(32'hC0C0_0000), t0 + 12);
        wait_ack(1'b0, 40, "stall"); ic_req = 1'b0; tick();

        // Reset mid-transaction, then a fresh grant while ic_req stays high.
        t0 = cyc; ic_addr = 32'h0000_0100; ic_req = 1'b1;
        push_beats(32'h0000_0100, 1'b0, 128'h0, 2);
        while (cyc < t0 + 4) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        n_vec++;
        if (mif.mem_en || ic_ack || dc_ack || ic_line != 128'h0) begin
            n_miss++;
            $display("FAIL reset_mid: got en %b ic_ack %b dc_ack %b line %h, required all zero",
                     mif.mem_en, ic_ack, dc_ack, ic_line);
        end
        push_beats(32'h0000_0100, 1'b0, 128'h0, 4);
        push_ack(1'b0, 1'b1, mk_line(32'hA0A0_0000), t0 + 14);
        wait_ack(1'b0, 40, "regrant"); ic_req = 1'b0; tick();

        // Top-of-memory line: no carry out of the line.
        t0 = cyc; dc_addr = 32'hFFFF_FFF8; dc_rd_wr = 1'b0; dc_req = 1'b1;
        push_beats(32'hFFFF_FFF0, 1'b0, 128'h0, 4);
        push_ack(1'b1, 1'b1, mk_line(32'hE0E0_0000), t0 + 9);
        wait_ack(1'b1, 40, "top_line"); dc_req = 1'b0; tick();

        repeat (5) tick();
        n_vec++;
        if (ack_q.size() != 0 || beat_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d acks and %0d beats outstanding, required 0 and 0",
                     ack_q.size(), beat_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Sequencer and arbiter that shares the single-ported main memory between the instruction-cache fill path and the data-cache fill/writeback path. Each granted request is a full 16-byte line moved as four sequential 32-bit word accesses. The memory sees one `en`/`rd_wr`/`addr` strobe per word. The block sits between both cache controllers and `main_memory_top`, and is the only master of the memory port.

## Interface
Parameters:
- `LINE_WORDS`, default 4: words per line; the line is 32*LINE_WORDS bits.
- `MEM_LAT`, default 2, minimum 1: cycles each word address is held before read data/write completion is sampled.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ic_req` in 1: icache line-read request, level; held until `ic_ack`.
- `ic_addr` in 32: icache line address; bits [3:0] ignored.
- `ic_ack` out 1: one-cycle pulse when `ic_line` is valid.
- `ic_line` out 128: fetched line; word k is bits [32k+31:32k].
- `dc_req` in 1: dcache request, level; held until `dc_ack`.
- `dc_rd_wr` in 1: 0 = line read, 1 = line write.
- `dc_addr` in 32: dcache line address; bits [3:0] ignored.
- `dc_wdata` in 128: write line; word k is bits [32k+31:32k].
- `dc_ack` out 1: one-cycle pulse when the read line is valid or the write is complete.
- `dc_line` out 128: fetched line for dcache reads.
- `mem_en` out 1: memory enable.
- `mem_rd_wr` out 1: 0 = read, 1 = write.
- `mem_addr` out 32: word address.
- `mem_wdata` out 32: write word.
- `mem_rdata` in 32: memory read data.
- `mem_valid` in 1: memory data/completion valid.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: word-access loop.
  - DONE: acknowledge cycle.
- In IDLE with at least one request, grant a requester:
  - Register the grant, the line base address (addr & ~0xF), the direction (`ic` is always a read) and the write line.
  - Clear the beat counter and the latency counter, then go to ACCESS.
- Arbitration is round-robin on simultaneous requests: grant the requester not served last.
  - After reset, `last_grant` = dcache, so icache wins the first tie.
  - A lone requester is always granted.
- ACCESS:
  - Drive `mem_en`=1, `mem_rd_wr` = direction, `mem_addr` = base + 4*beat, and `mem_wdata` = write word[beat].
  - The latency counter increments each cycle up to MEM_LAT-1.
  - At MEM_LAT-1 with `mem_valid`=1: on a read, capture `mem_rdata` into line-buffer word[beat]. Then advance beat and clear the latency counter.
  - At MEM_LAT-1 with `mem_valid`=0: hold all state (stall) until `mem_valid`.
  - Capturing beat LINE_WORDS-1 moves to DONE.
- DONE:
  - Pulse the granted requester's ack for one cycle. `ic_line` and `dc_line` both present the line buffer.
  - Update `last_grant` and return to IDLE.
  - The earliest new grant is in the following IDLE cycle, which gives one dead cycle between transactions.
- A requester dropping its `req` mid-transaction is a protocol violation. The transaction still completes and acks.
- The non-granted request is held pending, unaffected.

## Timing
- Reset values: all outputs are 0; state = IDLE; line buffer = 0; `last_grant` = dcache.
- A request sampled in IDLE at cycle t0 gives ACCESS from t0+1.
- Word k is sampled at t0+1+k*MEM_LAT+MEM_LAT-1, assuming no stall.
- Ack is at t0+1+LINE_WORDS*MEM_LAT. With the defaults, ack is at t0+9.
- Each cycle of `mem_valid`=0 at a sample point adds one cycle.
- `mem_en` is low in IDLE and DONE, and high for exactly LINE_WORDS*MEM_LAT cycles per transaction when there are no stalls.
- Address wrap: base + 4*beat is 32-bit modulo. Base 0xFFFFFFF0 accesses 0xFFFFFFF0 to 0xFFFFFFFC, with no carry out of the line.
- Reset mid-transaction:
  - Next cycle: IDLE, `mem_en`=0, no ack, line buffer cleared.
  - The requester must still hold `req`; it is re-granted from scratch.
- Ack and a new request in the same cycle: the new request is not granted until the following IDLE cycle.

## Structure
- Shared package `mem_pkg` holds:
  - the FSM state encoding;
  - the requester IDs (REQ_IC, REQ_DC);
  - the `LINE_WORDS` and `MEM_LAT` defaults;
  - the line-offset constant (4 bits).
- One sub-module, `mem_beat_counter`: beat index plus latency counter with stall input. It outputs `sample` and `last_beat`.
- The arbiter and FSM stay in the top.

## Test plan
- Single icache read, `ic_addr`=0x104, memory words at 0x100..0x10C = A0,A1,A2,A3 -> `mem_addr` goes 0x100,0x104,0x108,0x10C, two cycles each. `ic_ack` pulses at t0+9. `ic_line` = {A3,A2,A1,A0}.
- dcache write, `dc_addr`=0x200, `dc_wdata`={D3,D2,D1,D0} -> `mem_rd_wr`=1, `mem_wdata` = D0..D3 at 0x200..0x20C. `dc_ack` at t0+9; `ic_ack` stays 0.
- `ic_req` and `dc_req` asserted together and both held -> icache served first (ack at t0+9), dcache granted at t0+10 (ack at t0+19). The third simultaneous tie goes to icache again.
- `mem_valid` forced 0 for 3 cycles at beat 2's sample point -> ack delayed to t0+12; captured data correct.
- Reset asserted at t0+4 during an icache read -> next cycle `mem_en`=0 and no ack. With `ic_req` still high, a fresh grant follows and acks 9 cycles after re-grant.
- `dc_addr`=0xFFFFFFF8 read -> addresses 0xFFFFFFF0..0xFFFFFFFC, no wrap to 0.
